// File: rtl/arb_4x1_rr.sv
// arb_4x1_rr: round-robin arbiter and sequencer for a shared 4:1 select path.
// Grants one of four requesters at a time and moves its words into a
// registered output stage under a valid/ready handshake.
//
// Parameters:
//   DW         data word width per requester
//   MAX_BURST  beats per grant before forced release (1..255)
//
// Optional feature macro: ARB_4X1_BURST_LIMIT_EN
//   defined     a grant is also released once MAX_BURST beats have moved
//   undefined   a grant is held until the last beat or a request drop
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   req[k]      requester k has a word on its din slice
//   last[k]     current word of requester k ends its packet
//   din         requester k data at din[k*DW +: DW]
//   gnt         one-hot registered grant
//   sel         registered binary index of the granted requester
//   dout        registered output word
//   dout_valid  dout holds a word not yet taken
//   dout_ready  consumer takes dout this cycle when dout_valid=1
module arb_4x1_rr #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [3:0]    last,
    input  logic [4*DW-1:0] din,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready
);

`ifdef ARB_4X1_BURST_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    ptr;
    logic [1:0]    ptr_nxt;
    logic [1:0]    g;
    logic [1:0]    g_nxt;
    logic [7:0]    beat_cnt;
    logic [7:0]    beat_cnt_nxt;
    logic [3:0]    gnt_nxt;
    logic [1:0]    sel_nxt;
    logic [DW-1:0] dout_nxt;
    logic          dout_valid_nxt;

    // Handshake terms; accept and beat are what a requester sees as "taken".
    logic          accept;
    logic          beat;
    logic          req_g;
    logic          last_g;
    logic [DW-1:0] din_g;

    // Round-robin pick.
    logic [7:0]    req2;
    logic [3:0]    rot;
    logic [1:0]    off;
    logic [1:0]    pick;
    logic [3:0]    pick_oh;

    // Burst accounting.
    logic [7:0]    cnt_inc;
    logic          limit_hit;

    // Steer the granted requester's slice; this is the shared 4:1 select.
    always_comb begin
        req_g  = 1'b0;
        last_g = 1'b0;
        din_g  = '0;
        for (int k = 0; k < 4; k++) begin
            if (g == 2'(k)) begin
                req_g  = req[k];
                last_g = last[k];
                din_g  = din[k*DW +: DW];
            end
        end
    end

    assign accept = ~dout_valid | dout_ready;
    assign beat   = (state == BUSY) & req_g & accept;

    // Rotate so bit 0 is the requester at ptr, then take the first set bit.
    assign req2 = {req, req};
    assign rot  = req2[ptr +: 4];

    always_comb begin
        off = 2'd0;
        priority case (1'b1)
            rot[0]:  off = 2'd0;
            rot[1]:  off = 2'd1;
            rot[2]:  off = 2'd2;
            rot[3]:  off = 2'd3;
            default: off = 2'd0;
        endcase
    end

    assign pick    = ptr + off;
    assign pick_oh = 4'b0001 << pick;

    // Counter saturates so long packets never wrap it.
    assign cnt_inc   = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
    assign limit_hit = LIMIT_EN && (cnt_inc == MAX_B);

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        g_nxt          = g;
        beat_cnt_nxt   = beat_cnt;
        gnt_nxt        = gnt;
        sel_nxt        = sel;
        dout_nxt       = dout;
        dout_valid_nxt = dout_valid;

        // Word taken by the consumer; a same-cycle beat below overrides.
        if (dout_valid && dout_ready) begin
            dout_valid_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = BUSY;
                    g_nxt        = pick;
                    sel_nxt      = pick;
                    gnt_nxt      = pick_oh;
                    beat_cnt_nxt = 8'd0;
                end
            end
            BUSY: begin
                if (!req_g) begin
                    // Requester abandoned its packet: release, no beat.
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    ptr_nxt   = g + 2'd1;
                end else if (accept) begin
                    dout_nxt       = din_g;
                    dout_valid_nxt = 1'b1;
                    beat_cnt_nxt   = cnt_inc;
                    if (last_g || limit_hit) begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        ptr_nxt   = g + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            g          <= 2'd0;
            beat_cnt   <= 8'd0;
            gnt        <= 4'b0000;
            sel        <= 2'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            g          <= g_nxt;
            beat_cnt   <= beat_cnt_nxt;
            gnt        <= gnt_nxt;
            sel        <= sel_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
        end
    end

endmodule

// File: tb/tb_arb_4x1_rr.sv
// tb_arb_4x1_rr: directed self-checking bench for arb_4x1_rr.
// Inputs change #1 after a rising edge; outputs are checked at that point.
module tb_arb_4x1_rr;

    localparam int DW = 8;
    localparam int MB = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [3:0]    last;
    logic [4*DW-1:0] din;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_4x1_rr #(
        .DW(DW),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .last(last),
        .din(din),
        .gnt(gnt),
        .sel(sel),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic [7:0] v, input logic l);
        din[k*DW +: DW] = v;
        last[k] = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        last = 4'b0000;
        din = '0;
        dout_ready = 1'b1;
        cyc();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt got %b exp 0000", gnt);
        end
        checks++;
        if (sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_sel got %0d exp 0", sel);
        end
        checks++;
        if (dout !== 8'h00 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got %h/%b exp 00/0", dout, dout_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [7:0] w;
        logic [3:0] eg;
        req = 4'b1111;
        last = 4'b1111;
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 8'hD0 + 8'(k);
            put(k, w, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            eg = 4'b0001 << (i % 4);
            w = 8'hD0 + 8'(i % 4);
            cyc();
            checks++;
            if (gnt !== eg || sel !== 2'(i % 4)) begin
                errors++;
                $display("FAIL rr_grant%0d got %b/%0d exp %b/%0d",
                         i, gnt, sel, eg, i % 4);
            end
            cyc();
            checks++;
            if (gnt !== 4'b0000 || sel !== 2'(i % 4)) begin
                errors++;
                $display("FAIL rr_idle%0d got %b/%0d exp 0000/%0d",
                         i, gnt, sel, i % 4);
            end
            checks++;
            if (dout !== w || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_dout%0d got %h/%b exp %h/1",
                         i, dout, dout_valid, w);
            end
        end
        req = 4'b0000;
        cyc();
        checks++;
        if (dout_valid !== 1'b0 || dut.ptr !== 2'd1) begin
            errors++;
            $display("FAIL rr_drain got %b/%0d exp 0/1", dout_valid, dut.ptr);
        end
    endtask

    task automatic test_burst();
        req = 4'b0100;
        put(2, 8'h11, 1'b0);
        cyc();
        checks++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            errors++;
            $display("FAIL burst_grant got %b/%0d exp 0100/2", gnt, sel);
        end
        req = 4'b0101;
        cyc();
        checks++;
        if (dout !== 8'h11 || dout_valid !== 1'b1 || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL burst_b0 got %h/%b/%b exp 11/1/0100",
                     dout, dout_valid, gnt);
        end
        put(2, 8'h22, 1'b0);
        req = 4'b0110;
        cyc();
        checks++;
        if (dout !== 8'h22 || dout_valid !== 1'b1 || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL burst_b1 got %h/%b/%b exp 22/1/0100",
                     dout, dout_valid, gnt);
        end
        put(2, 8'h33, 1'b1);
        req = 4'b0100;
        cyc();
        checks++;
        if (dout !== 8'h33 || gnt !== 4'b0000 || dut.ptr !== 2'd3) begin
            errors++;
            $display("FAIL burst_end got %h/%b/%0d exp 33/0000/3",
                     dout, gnt, dut.ptr);
        end
        req = 4'b0000;
        cyc();
    endtask

    task automatic test_backpressure();
        req = 4'b0010;
        put(1, 8'hA1, 1'b0);
        dout_ready = 1'b1;
        cyc();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant got %b exp 0010", gnt);
        end
        cyc();
        put(1, 8'hA2, 1'b0);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (dout !== 8'hA1 || dout_valid !== 1'b1 || gnt !== 4'b0010) begin
                errors++;
                $display("FAIL bp_hold%0d got %h/%b/%b exp a1/1/0010",
                         i, dout, dout_valid, gnt);
            end
        end
        dout_ready = 1'b1;
        cyc();
        checks++;
        if (dout !== 8'hA2 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL bp_resume got %h/%b exp a2/0010", dout, gnt);
        end
        put(1, 8'hA3, 1'b1);
        cyc();
        checks++;
        if (dout !== 8'hA3 || dout_valid !== 1'b1 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL bp_end got %h/%b/%b exp a3/1/0000",
                     dout, dout_valid, gnt);
        end
        req = 4'b0000;
        cyc();
        checks++;
        if (dout_valid !== 1'b0 || dut.ptr !== 2'd2) begin
            errors++;
            $display("FAIL bp_drain got %b/%0d exp 0/2", dout_valid, dut.ptr);
        end
    endtask

    task automatic test_abandon();
        req = 4'b0010;
        put(1, 8'hB1, 1'b0);
        cyc();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL ab_grant got %b exp 0010", gnt);
        end
        cyc();
        req = 4'b0100;
        put(2, 8'hC1, 1'b1);
        cyc();
        checks++;
        if (gnt !== 4'b0000 || dout_valid !== 1'b0 || dout !== 8'hB1
            || dut.ptr !== 2'd2) begin
            errors++;
            $display("FAIL ab_release got %b/%b/%h/%0d exp 0000/0/b1/2",
                     gnt, dout_valid, dout, dut.ptr);
        end
        cyc();
        checks++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            errors++;
            $display("FAIL ab_next got %b/%0d exp 0100/2", gnt, sel);
        end
        cyc();
        checks++;
        if (dout !== 8'hC1 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL ab_dout got %h/%b exp c1/1", dout, dout_valid);
        end
        req = 4'b0000;
        cyc();
    endtask

    task automatic test_reset_mid();
        req = 4'b1000;
        put(3, 8'hE1, 1'b0);
        cyc();
        cyc();
        checks++;
        if (dout_valid !== 1'b1 || gnt !== 4'b1000) begin
            errors++;
            $display("FAIL mid_setup got %b/%b exp 1/1000", dout_valid, gnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || dout !== 8'h00
            || dout_valid !== 1'b0 || dut.ptr !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset got %b/%0d/%h/%b/%0d exp 0000/0/00/0/0",
                     gnt, sel, dout, dout_valid, dut.ptr);
        end
        rst_n = 1'b1;
        req = 4'b1111;
        last = 4'b1111;
        cyc();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_first got %b/%0d exp 0001/0", gnt, sel);
        end
        req = 4'b0000;
        cyc();
        cyc();
    endtask

    task automatic test_burst_cfg();
`ifdef ARB_4X1_BURST_LIMIT_EN
        localparam int N = 12;
        logic [3:0] eg [N] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010,
                               4'b0000, 4'b0001, 4'b0001, 4'b0000,
                               4'b0010, 4'b0000, 4'b0001, 4'b0000};
        int eb [N] = '{-1, 0, 0, -1, 1, -1, 0, 0, -1, 1, -1, 0};
        int drop_at = 9;
`else
        localparam int N = 6;
        logic [3:0] eg [N] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0000};
        int eb [N] = '{-1, 0, 0, 0, 0, 0};
        int drop_at = 5;
`endif
        int n0 = 0;
        logic [7:0] w;
        rst_n = 1'b0;
        req = 4'b0000;
        dout_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        req = 4'b0011;
        put(0, 8'hA0, 1'b0);
        put(1, 8'h5A, 1'b1);
        for (int e = 0; e < N; e++) begin
            cyc();
            checks++;
            if (gnt !== eg[e]) begin
                errors++;
                $display("FAIL cfg_gnt%0d got %b exp %b", e, gnt, eg[e]);
            end
            if (eb[e] >= 0) begin
                w = (eb[e] == 0) ? 8'hA0 + 8'(n0) : 8'h5A;
                checks++;
                if (dout !== w || dout_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL cfg_dout%0d got %h/%b exp %h/1",
                             e, dout, dout_valid, w);
                end
                if (eb[e] == 0) begin
                    n0++;
                    w = 8'hA0 + 8'(n0);
                    put(0, w, n0 == 4);
                end
            end
            if (e == drop_at) begin
                req[1] = 1'b0;
            end
        end
        req = 4'b0000;
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_abandon();
        test_reset_mid();
        test_burst_cfg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_4x1_rr.md
# arb_4x1_rr

Round-robin arbiter and sequencer for a 4-to-1 select datapath. Four requesters share one output channel: the block grants one requester at a time, drives the 2-bit select that steers the shared 4:1 selection, and moves the granted requester's data words through a registered output stage with a valid/ready handshake. Sits between four producer ports and a single downstream consumer.

## Interface
- DW, 8: data word width per requester.
- MAX_BURST, 4: beats per grant before forced release (used only with ARB_4X1_BURST_LIMIT_EN; legal 1..255).

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  req[k]: requester k has a word on its data slice.
- last  in  4  last[k]: current word of requester k ends its packet.
- din  in  4*DW  requester k data at din[k*DW +: DW].
- gnt  out  4  one-hot grant, registered.
- sel  out  2  binary index of granted requester, registered.
- dout  out  DW  registered output word.
- dout_valid  out  1  dout holds an untaken word.
- dout_ready  in  1  consumer takes dout this cycle when dout_valid=1.

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, BUSY. Internal: ptr[1:0] (next priority start), g[1:0] (granted index), beat_cnt[7:0].
- accept = ~dout_valid | dout_ready. beat = BUSY & req[g] & accept.
- IDLE: if req≠0, select first k with req[k]=1 scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); next cycle BUSY, gnt=1<<k, sel=k, g=k, beat_cnt=0. If req=0 stay IDLE.
- BUSY on beat: dout<=din[g], dout_valid<=1, beat_cnt+1. If last[g]=1: release.
- BUSY, req[g]=0 (requester abandons): release, no beat.
- BUSY, req[g]=1 & ~accept: hold; no state change.
- Release: next cycle IDLE, gnt=0, ptr=g+1 mod 4 (wraps 3->0), sel keeps g.
- Output stage: if dout_valid & dout_ready & ~beat then dout_valid<=0; dout keeps value.
- Requesters observe transfer as gnt[k] & req[k] & accept; they must hold din/last stable otherwise (accept exported implicitly: block drives no separate ready; requester treats gnt[k]=1 plus dout_ready or empty stage as taken — implementer exposes accept internally for bench probing).
- req changes of non-granted requesters never affect current grant.

## Timing
- Reset values: gnt=0, sel=0, dout=0, dout_valid=0, state IDLE, ptr=0, beat_cnt=0.
- Arbitration latency: req seen in IDLE at edge N -> gnt at N+1; first beat captured at edge N+2 if accept -> dout_valid high after N+2.
- Streaming: one beat per cycle while req[g] & dout_ready held.
- After release: at least one IDLE cycle before next grant (no back-to-back grant).
- Simultaneous beat and dout_ready: dout replaced, dout_valid stays 1.
- Reset mid-burst: all outputs return to reset values immediately; partial packet dropped; ptr=0.
- sel is stable whenever gnt≠0.

## Configuration
- ARB_4X1_BURST_LIMIT_EN defined: release also when a beat makes beat_cnt reach MAX_BURST, even if last[g]=0; ptr advances as normal release; requester re-arbitrates for remainder.
- Not defined: grant held until last[g] beat or req[g] drop; beat_cnt still counts (saturates at 255), MAX_BURST ignored.

## Test plan
- Reset: rst_n low mid-stream with dout_valid=1 -> gnt=0, sel=0, dout=0, dout_valid=0 same cycle; first grant after reset with req=4'b1111 goes to k=0.
- Round-robin: req=4'b1111, every word last=1, dout_ready=1 -> grant order 0,1,2,3,0; sel 0,1,2,3,0; one IDLE cycle between grants.
- Burst: requester 2 sends 0x11,0x22,0x33 (last on 0x33), dout_ready=1 -> dout 0x11,0x22,0x33 on consecutive cycles, gnt=4'b0100 throughout, then ptr=3.
- Backpressure: dout_ready=0 for 3 cycles during burst -> dout holds first word, no new capture, gnt held; ready high -> stream resumes with no loss or duplicate.
- Abandon: req[1] drops mid-packet without last -> release next cycle, ptr=2, req[2] next granted.
- Burst limit (macro defined, MAX_BURST=2): requester 0 sends 5 words, req=4'b0011 -> grants 0(2 beats),1,0(2 beats),1,0(1 beat).
